// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: registers EX results into WB and completes loads against a
// variable-latency data-SRAM read response, with byte/half/word alignment and extension.
module mem_lsu_stage #(
    parameter int PC_W    = 32,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int MEMOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_valid_i,
    input  logic [PC_W-1:0]    mem_inst_i,
    input  logic [PC_W-1:0]    mem_pc_i,
    input  logic               mem_inslot_i,
    input  logic [MEMOP_W-1:0] mem_memop_i,
    input  logic [1:0]         mem_addr_lo_i,
    input  logic [REG_AW-1:0]  mem_waddr_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic               mem_wren_i,
    input  logic               mem_stall_i,
    input  logic               mem_flush_i,
    input  logic               dsram_rvalid_i,
    input  logic [DATA_W-1:0]  dsram_rdata_i,
    output logic               mem_valid_o,
    output logic [PC_W-1:0]    mem_inst_o,
    output logic [PC_W-1:0]    mem_pc_o,
    output logic               mem_inslot_o,
    output logic [MEMOP_W-1:0] mem_memop_o,
    output logic [REG_AW-1:0]  mem_waddr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    output logic               mem_wren_o,
    output logic               mem_stall_o
);

    if (DATA_W != 32) begin : g_bad_width
        $error("mem_lsu_stage supports DATA_W = 32 only");
    end

    localparam logic [MEMOP_W-1:0] OP_LB  = MEMOP_W'(1);
    localparam logic [MEMOP_W-1:0] OP_LBU = MEMOP_W'(2);
    localparam logic [MEMOP_W-1:0] OP_LH  = MEMOP_W'(3);
    localparam logic [MEMOP_W-1:0] OP_LHU = MEMOP_W'(4);
    localparam logic [MEMOP_W-1:0] OP_LW  = MEMOP_W'(5);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t              state_reg;
    logic [DATA_W-1:0]   hold_reg;

    logic                is_load;
    logic                have_data;
    logic                en;
    logic [DATA_W-1:0]   load_src;
    logic [DATA_W-1:0]   load_ext;
    logic [7:0]          byte_lane [4];
    logic [15:0]         half_lane [2];
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;

    logic               valid_reg;
    logic [PC_W-1:0]    inst_reg;
    logic [PC_W-1:0]    pc_reg;
    logic               inslot_reg;
    logic [MEMOP_W-1:0] memop_reg;
    logic [REG_AW-1:0]  waddr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic               wren_reg;

    assign is_load   = mem_valid_i && (mem_memop_i >= OP_LB) && (mem_memop_i <= OP_LW);
    assign have_data = (state_reg == S_HOLD) ? 1'b1
                     : (state_reg == S_DRAIN) ? 1'b0 : dsram_rvalid_i;
    // A held response takes precedence over the live bus, which may already carry garbage.
    assign load_src  = (state_reg == S_HOLD) ? hold_reg : dsram_rdata_i;

    assign mem_stall_o = is_load && !have_data && !mem_flush_i && (state_reg != S_DRAIN);
    assign en          = !mem_stall_i && !mem_stall_o && (state_reg != S_DRAIN);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign byte_lane[gi] = load_src[gi*8 +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
        assign half_lane[gi] = load_src[gi*16 +: 16];
    end

    assign byte_sel = byte_lane[mem_addr_lo_i];
    assign half_sel = half_lane[mem_addr_lo_i[1]];

    always_comb begin
        load_ext = load_src;
        case (mem_memop_i)
            OP_LB:   load_ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            OP_LBU:  load_ext = {{(DATA_W-8){1'b0}}, byte_sel};
            OP_LH:   load_ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
            OP_LHU:  load_ext = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_ext = load_src;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            hold_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!mem_flush_i && is_load) begin
                        if (!dsram_rvalid_i) begin
                            state_reg <= S_WAIT;
                        end else if (mem_stall_i) begin
                            state_reg <= S_HOLD;
                            hold_reg  <= dsram_rdata_i;
                        end
                    end
                end
                S_WAIT: begin
                    if (dsram_rvalid_i) begin
                        if (mem_stall_i && !mem_flush_i) begin
                            state_reg <= S_HOLD;
                            hold_reg  <= dsram_rdata_i;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else if (mem_flush_i) begin
                        state_reg <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (mem_flush_i || !mem_stall_i) begin
                        state_reg <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (dsram_rvalid_i) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            inst_reg   <= '0;
            pc_reg     <= '0;
            inslot_reg <= 1'b0;
            memop_reg  <= '0;
            waddr_reg  <= '0;
            wdata_reg  <= '0;
            wren_reg   <= 1'b0;
        end else if (mem_flush_i) begin
            valid_reg <= 1'b0;
            wren_reg  <= 1'b0;
        end else if (en) begin
            valid_reg  <= mem_valid_i;
            inst_reg   <= mem_inst_i;
            pc_reg     <= mem_pc_i;
            inslot_reg <= mem_inslot_i;
            memop_reg  <= mem_memop_i;
            waddr_reg  <= mem_waddr_i;
            wdata_reg  <= is_load ? load_ext : mem_wdata_i;
            wren_reg   <= mem_wren_i && mem_valid_i;
        end
    end

    assign mem_valid_o  = valid_reg;
    assign mem_inst_o   = inst_reg;
    assign mem_pc_o     = pc_reg;
    assign mem_inslot_o = inslot_reg;
    assign mem_memop_o  = memop_reg;
    assign mem_waddr_o  = waddr_reg;
    assign mem_wdata_o  = wdata_reg;
    assign mem_wren_o   = wren_reg;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed-vector bench for mem_lsu_stage with hand-computed expected results.
module tb_mem_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_inst_i;
    logic [31:0] mem_pc_i;
    logic        mem_inslot_i;
    logic [3:0]  mem_memop_i;
    logic [1:0]  mem_addr_lo_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_wren_i;
    logic        mem_stall_i;
    logic        mem_flush_i;
    logic        dsram_rvalid_i;
    logic [31:0] dsram_rdata_i;
    logic        mem_valid_o;
    logic [31:0] mem_inst_o;
    logic [31:0] mem_pc_o;
    logic        mem_inslot_o;
    logic [3:0]  mem_memop_o;
    logic [4:0]  mem_waddr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_wren_o;
    logic        mem_stall_o;

    int errors = 0;
    int checks = 0;

    mem_lsu_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid_i    (mem_valid_i),
        .mem_inst_i     (mem_inst_i),
        .mem_pc_i       (mem_pc_i),
        .mem_inslot_i   (mem_inslot_i),
        .mem_memop_i    (mem_memop_i),
        .mem_addr_lo_i  (mem_addr_lo_i),
        .mem_waddr_i    (mem_waddr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_wren_i     (mem_wren_i),
        .mem_stall_i    (mem_stall_i),
        .mem_flush_i    (mem_flush_i),
        .dsram_rvalid_i (dsram_rvalid_i),
        .dsram_rdata_i  (dsram_rdata_i),
        .mem_valid_o    (mem_valid_o),
        .mem_inst_o     (mem_inst_o),
        .mem_pc_o       (mem_pc_o),
        .mem_inslot_o   (mem_inslot_o),
        .mem_memop_o    (mem_memop_o),
        .mem_waddr_o    (mem_waddr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_wren_o     (mem_wren_o),
        .mem_stall_o    (mem_stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Inputs change 1ns after the rising edge, so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic [3:0] op, input logic [1:0] lo, input logic [31:0] alu,
                        input logic rv, input logic [31:0] rd);
        mem_valid_i    = 1'b1;
        mem_memop_i    = op;
        mem_addr_lo_i  = lo;
        mem_wdata_i    = alu;
        mem_wren_i     = 1'b1;
        mem_waddr_i    = 5'd5;
        mem_pc_i       = 32'h0000_1000;
        mem_inst_i     = 32'h8C00_0000;
        dsram_rvalid_i = rv;
        dsram_rdata_i  = rd;
    endtask

    task automatic empty_slot();
        mem_valid_i    = 1'b0;
        mem_memop_i    = 4'd0;
        dsram_rvalid_i = 1'b0;
        dsram_rdata_i  = 32'h0;
    endtask

    // Single-cycle transaction: present, check no stall, clock, check result.
    task automatic one_cycle(input string tag, input logic [3:0] op, input logic [1:0] lo,
                             input logic rv, input logic [31:0] rd, input logic [31:0] exp);
        slot(op, lo, 32'hCAFE_BABE, rv, rd);
        #1 check({tag, " stall"}, {31'b0, mem_stall_o}, 32'd0);
        tick();
        check({tag, " wdata"}, mem_wdata_o, exp);
        empty_slot();
    endtask

    initial begin
        rst = 1'b1;
        mem_inslot_i = 1'b0;
        mem_stall_i  = 1'b0;
        mem_flush_i  = 1'b0;
        mem_inst_i   = '0;
        mem_pc_i     = '0;
        mem_waddr_i  = '0;
        mem_wdata_i  = '0;
        mem_wren_i   = 1'b0;
        mem_addr_lo_i = '0;
        empty_slot();
        tick();
        tick();
        check("reset valid_o", {31'b0, mem_valid_o}, 32'd0);
        check("reset wdata_o", mem_wdata_o, 32'd0);
        check("reset wren_o", {31'b0, mem_wren_o}, 32'd0);
        rst = 1'b0;
        tick();

        // LW with same-cycle response
        slot(4'd5, 2'd0, 32'hCAFE_BABE, 1'b1, 32'h1234_5678);
        #1 check("lw0 stall", {31'b0, mem_stall_o}, 32'd0);
        tick();
        check("lw0 wdata", mem_wdata_o, 32'h1234_5678);
        check("lw0 wren", {31'b0, mem_wren_o}, 32'd1);
        check("lw0 valid", {31'b0, mem_valid_o}, 32'd1);
        check("lw0 waddr", {27'b0, mem_waddr_o}, 32'd5);
        empty_slot();

        // Extension cases on rdata = 0x80FF1234
        one_cycle("lb3",  4'd1, 2'd3, 1'b1, 32'h80FF_1234, 32'hFFFF_FF80);
        one_cycle("lbu1", 4'd2, 2'd1, 1'b1, 32'h80FF_1234, 32'h0000_0012);
        one_cycle("lhu2", 4'd4, 2'd2, 1'b1, 32'h80FF_1234, 32'h0000_80FF);
        one_cycle("lh2",  4'd3, 2'd2, 1'b1, 32'h80FF_1234, 32'hFFFF_80FF);
        one_cycle("lh1",  4'd3, 2'd1, 1'b1, 32'h80FF_1234, 32'h0000_1234);
        one_cycle("lb0",  4'd1, 2'd0, 1'b1, 32'h0000_0085, 32'hFFFF_FF85);
        one_cycle("alu",  4'd0, 2'd0, 1'b0, 32'h0, 32'hCAFE_BABE);
        one_cycle("sw",   4'd8, 2'd0, 1'b0, 32'h0, 32'hCAFE_BABE);
        one_cycle("op9",  4'd9, 2'd0, 1'b0, 32'h0, 32'hCAFE_BABE);

        // Invalid slot: wren gated off
        slot(4'd0, 2'd0, 32'h1, 1'b0, 32'h0);
        mem_valid_i = 1'b0;
        tick();
        check("inv wren", {31'b0, mem_wren_o}, 32'd0);
        check("inv valid", {31'b0, mem_valid_o}, 32'd0);
        empty_slot();

        // LW with response 3 cycles late
        slot(4'd5, 2'd0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("late stall c%0d", i), {31'b0, mem_stall_o}, 32'd1);
            tick();
        end
        dsram_rvalid_i = 1'b1;
        dsram_rdata_i  = 32'hA5A5_0001;
        #1 check("late stall end", {31'b0, mem_stall_o}, 32'd0);
        tick();
        check("late wdata", mem_wdata_o, 32'hA5A5_0001);
        empty_slot();

        // Response arrives under downstream stall -> HOLD
        slot(4'd5, 2'd0, 32'h0, 1'b1, 32'h1122_3344);
        mem_stall_i = 1'b1;
        tick();
        dsram_rvalid_i = 1'b0;
        dsram_rdata_i  = 32'hBBBB_BBBB;
        tick();
        check("hold keeps wdata", mem_wdata_o, 32'hA5A5_0001);
        mem_stall_i = 1'b0;
        #1 check("hold stall", {31'b0, mem_stall_o}, 32'd0);
        tick();
        check("hold wdata", mem_wdata_o, 32'h1122_3344);
        empty_slot();

        // Flush in WAIT, drain the late response
        slot(4'd5, 2'd0, 32'h0, 1'b0, 32'h0);
        tick();
        mem_flush_i = 1'b1;
        #1 check("flush stall", {31'b0, mem_stall_o}, 32'd0);
        tick();
        mem_flush_i = 1'b0;
        check("flush valid", {31'b0, mem_valid_o}, 32'd0);
        check("flush wren", {31'b0, mem_wren_o}, 32'd0);
        #1 check("drain stall", {31'b0, mem_stall_o}, 32'd0);
        tick();
        dsram_rvalid_i = 1'b1;
        dsram_rdata_i  = 32'hDEAD_0000;
        tick();
        check("drain no dead", {31'b0, (mem_wdata_o == 32'hDEAD_0000)}, 32'd0);
        slot(4'd5, 2'd0, 32'h0, 1'b1, 32'h0000_0001);
        tick();
        check("post drain wdata", mem_wdata_o, 32'h0000_0001);
        check("post drain valid", {31'b0, mem_valid_o}, 32'd1);
        empty_slot();

        // Asynchronous reset while waiting
        slot(4'd5, 2'd0, 32'h0, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        #1 check("arst valid", {31'b0, mem_valid_o}, 32'd0);
        check("arst wdata", mem_wdata_o, 32'd0);
        #1 rst = 1'b0;
        slot(4'd5, 2'd0, 32'h0, 1'b1, 32'h5555_AAAA);
        #1 check("arst fresh stall", {31'b0, mem_stall_o}, 32'd0);
        tick();
        check("arst fresh wdata", mem_wdata_o, 32'h5555_AAAA);
        check("arst fresh valid", {31'b0, mem_valid_o}, 32'd1);
        empty_slot();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
